// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for DIV/DIVU, one quotient bit per cycle.
// Ports: clk, rst (sync, active-low), start/signed_div/a/b request, annul flush,
//        result {rem,quot} valid with ready pulse, stall holds the pipeline.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DIVZERO = 2'd1;
    localparam logic [1:0] S_ON      = 2'd2;
    localparam logic [1:0] S_END     = 2'd3;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0]   dvsr;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] res_q;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] work_nxt;
    logic [WIDTH-1:0]   q_fin;
    logic [WIDTH-1:0]   r_fin;

    assign a_abs = (signed_div && a[WIDTH-1]) ? -a : a;
    assign b_abs = (signed_div && b[WIDTH-1]) ? -b : b;

    // The top WIDTH+1 bits of the shifted value are compared in full;
    // the subtraction only needs WIDTH bits since the difference < dvsr.
    assign shifted = {work, 1'b0};
    assign ge      = shifted[2*WIDTH:WIDTH] >= {1'b0, dvsr};
    assign diff    = shifted[2*WIDTH-1:WIDTH] - dvsr;

    always_comb begin
        work_nxt = shifted[2*WIDTH-1:0];
        if (ge) begin
            work_nxt = {diff, shifted[WIDTH-1:1], 1'b1};
        end
    end

    assign q_fin = neg_q ? -work_nxt[WIDTH-1:0] : work_nxt[WIDTH-1:0];
    assign r_fin = neg_r ? -work_nxt[2*WIDTH-1:WIDTH]
                         : work_nxt[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            work  <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            res_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && !annul) begin
                        if (b == '0) begin
                            state <= S_DIVZERO;
                        end else begin
                            state <= S_ON;
                            work  <= {{WIDTH{1'b0}}, a_abs};
                            dvsr  <= b_abs;
                            neg_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r <= signed_div & a[WIDTH-1];
                            cnt   <= '0;
                        end
                    end
                end
                S_DIVZERO: begin
                    if (annul) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_END;
                        res_q <= '0;
                    end
                end
                S_ON: begin
                    if (annul) begin
                        state <= S_IDLE;
                    end else begin
                        work <= work_nxt;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= S_END;
                            res_q <= {r_fin, q_fin};
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign result = res_q;
    assign ready  = (state == S_END);
    // Not stalled in END: the pipeline moves on the edge that takes result.
    assign stall  = (state == S_IDLE && start && !annul)
                  || state == S_ON || state == S_DIVZERO;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq.
// Drives after posedge, samples on negedge.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int checks = 0;
    int failures = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string nm, input bit sd,
                           input logic [31:0] aa, input logic [31:0] bb,
                           input logic [63:0] exp, input bit start_in_end);
        int lat;
        lat = (bb == 32'd0) ? 2 : 33;
        signed_div = sd;
        a = aa;
        b = bb;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL %s c0_stall got=%b exp=1", nm, stall);
        end
        adv();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        signed_div = ~sd;
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || stall !== 1'b1) begin
                failures++;
                $display("FAIL %s busy c%0d ready=%b stall=%b exp 0/1",
                         nm, c, ready, stall);
            end
            adv();
        end
        if (start_in_end) start = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || stall !== 1'b0 || result !== exp) begin
            failures++;
            $display("FAIL %s end ready=%b stall=%b result=%h exp 1/0/%h",
                     nm, ready, stall, result, exp);
        end
        adv();
        start = 1'b0;
        if (start_in_end) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                checks++;
                if (ready !== 1'b0 || stall !== 1'b0) begin
                    failures++;
                    $display("FAIL %s end_start_ignored ready=%b stall=%b exp 0/0",
                             nm, ready, stall);
                end
                adv();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        adv();
        adv();
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || stall !== 1'b0 || result !== 64'd0) begin
            failures++;
            $display("FAIL reset ready=%b stall=%b result=%h exp 0/0/0",
                     ready, stall, result);
        end
        rst = 1'b1;
        adv();
    endtask

    task automatic test_divu();
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,
                {32'd0, 32'hFFFF_FFFF}, 1'b0);
    endtask

    task automatic test_signed();
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
                {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
                {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                {32'd0, 32'h8000_0000}, 1'b0);
        run_div("divu_no_sign", 1'b0, 32'hFFFF_FFF9, 32'd2,
                {32'd1, 32'h7FFF_FFFC}, 1'b0);
    endtask

    task automatic test_divzero();
        run_div("divzero", 1'b0, 32'd123, 32'd0, 64'd0, 1'b0);
    endtask

    task automatic test_annul();
        signed_div = 1'b0;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        adv();
        start = 1'b0;
        for (int c = 1; c < 10; c++) adv();
        annul = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL annul c10_stall got=%b exp=1", stall);
        end
        adv();
        annul = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL annul c11 stall=%b ready=%b exp 0/0", stall, ready);
        end
        adv();
        run_div("after_annul", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0);
    endtask

    task automatic test_start_annul();
        signed_div = 1'b0;
        a = 32'd9;
        b = 32'd3;
        start = 1'b1;
        annul = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL start_annul stall=%b exp=0", stall);
        end
        adv();
        start = 1'b0;
        annul = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (stall !== 1'b0 || ready !== 1'b0) begin
                failures++;
                $display("FAIL start_annul idle stall=%b ready=%b exp 0/0",
                         stall, ready);
            end
            adv();
        end
    endtask

    task automatic test_reset_mid();
        signed_div = 1'b0;
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        adv();
        start = 1'b0;
        for (int c = 1; c < 15; c++) adv();
        rst = 1'b0;
        adv();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || stall !== 1'b0 || result !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid ready=%b stall=%b result=%h exp 0/0/0",
                     ready, stall, result);
        end
        adv();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || stall !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid stale ready=%b stall=%b exp 0/0",
                         ready, stall);
            end
            adv();
        end
        run_div("after_reset", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_div("b2b_1", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 1'b0);
        run_div("b2b_2", 1'b1, 32'hFFFF_FF9C, 32'd7,
                {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b1);
        run_div("b2b_3", 1'b1, 32'd0, 32'hFFFF_FFFF, 64'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        signed_div = 1'b0;
        a = '0;
        b = '0;
        annul = 1'b0;
        test_reset();
        test_divu();
        test_signed();
        test_divzero();
        test_annul();
        test_start_annul();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
